// File: rtl/instr_encoder.sv
// Encodes symbolic RV32I requests (R/LOAD/STORE/BEQ/ADDI) into a DEPTH-entry FIFO; one-cycle push-to-output latency.
// Backpressure: in_ready drops only on a registered full count; out_* hold while out_valid && !out_ready.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_kind,
    input  logic [2:0]               in_funct3,
    input  logic                     in_f7b5,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [12:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_take;
    logic        w_push;
    logic        w_pop;
    logic        w_unused_imm0;

    // Branch offsets are always even, so bit 0 of the immediate never reaches the word.
    assign w_unused_imm0 = in_imm[0];

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_kind)
            3'd0: w_word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd2: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd3: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            3'd4: w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            default: w_legal = 1'b0;
        endcase
    end

    assign in_ready    = (r_count < CW'(DEPTH));
    assign out_valid   = (r_count != '0);
    assign w_take      = in_valid && in_ready;
    assign w_push      = w_take && w_legal;
    assign w_pop       = out_valid && out_ready;
    assign out_instr   = r_mem[r_rd_ptr];
    assign out_addr    = r_addr;
    assign err_illegal = r_err;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_addr   <= r_addr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // An illegal request is consumed but only leaves a one-cycle error trace.
            r_err <= w_take && !w_legal;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus random stimulus for instr_encoder, checked against a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, err_a;
    logic [31:0] instr_a;
    logic [7:0]  addr_a;
    logic [2:0]  count_a;

    logic        in_ready_b, out_valid_b, err_b;
    logic [31:0] instr_b;
    logic [1:0]  addr_b;
    logic [2:0]  count_b;

    int errors = 0;
    int checks = 0;

    bit [31:0] q[$];
    int        popped;
    bit        err_m;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(instr_a),
        .out_addr(addr_a), .err_illegal(err_a), .count(count_a)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(instr_b),
        .out_addr(addr_b), .err_illegal(err_b), .count(count_b)
    );

    // Instruction word assembled field by field from the ISA layout.
    function automatic bit [31:0] ref_enc(int kind, int f3, int f7, int rd, int rs1, int rs2, int imm);
        bit [31:0] i12, b;
        i12 = 32'(imm & 'hFFF);
        b   = 32'(imm & 'h1FFE);
        case (kind)
            0: return (32'(f7) << 30) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
            1: return (i12 << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h03;
            2: return ((i12 >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | ((i12 & 32'h1F) << 7) | 32'h23;
            3: return (((b >> 12) & 1) << 31) | (((b >> 5) & 63) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (((b >> 1) & 15) << 8) | (((b >> 11) & 1) << 7) | 32'h63;
            default: return (i12 << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",  {31'b0, in_ready_a},  {31'b0, q.size() < 4});
        chk("out_valid", {31'b0, out_valid_a}, {31'b0, q.size() != 0});
        chk("count",     {29'b0, count_a},     32'(q.size()));
        chk("err",       {31'b0, err_a},       {31'b0, err_m});
        chk("addr",      {24'b0, addr_a},      32'(popped % 256));
        chk("addr_w2",   {30'b0, addr_b},      32'(popped % 4));
        chk("count_w2",  {29'b0, count_b},     32'(q.size()));
        chk("err_w2",    {31'b0, err_b},       {31'b0, err_m});
        chk("in_rdy_w2", {31'b0, in_ready_b},  {31'b0, q.size() < 4});
        chk("ovld_w2",   {31'b0, out_valid_b}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instr",    instr_a, q[0]);
            chk("instr_w2", instr_b, q[0]);
        end
    endtask

    task automatic tick();
        bit rdy, vld, take, legal;
        rdy   = q.size() < 4;
        vld   = q.size() != 0;
        take  = in_valid && rdy;
        legal = int'(in_kind) <= 4;
        @(posedge clk);
        if (reset) begin
            q.delete();
            popped = 0;
            err_m  = 1'b0;
        end else begin
            if (vld && out_ready) begin
                void'(q.pop_front());
                popped++;
            end
            if (take && legal)
                q.push_back(ref_enc(int'(in_kind), int'(in_funct3), int'(in_f7b5), int'(in_rd),
                                    int'(in_rs1), int'(in_rs2), int'($signed(in_imm))));
            err_m = take && !legal;
        end
        #1;
        check_all();
    endtask

    task automatic set_req(int kind, int f3, int f7, int rd, int rs1, int rs2, int imm);
        in_valid  = 1'b1;
        in_kind   = 3'(kind);
        in_funct3 = 3'(f3);
        in_f7b5   = 1'(f7);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_imm    = 13'(imm);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        popped = 0; err_m = 1'b0;
        tick();
        tick();
        chk("rst_instr",    instr_a, 32'h0);
        chk("rst_instr_w2", instr_b, 32'h0);
        reset = 1'b0;

        // T1: R-type ADD then SUB, streaming straight through
        out_ready = 1'b1;
        set_req(0, 0, 0, 3, 1, 2, 0); tick();
        chk("T1_add", instr_a, 32'h002081B3);
        chk("T1_add_addr", {24'b0, addr_a}, 32'd0);
        set_req(0, 0, 1, 5, 6, 7, 0); tick();
        chk("T1_sub", instr_a, 32'h407302B3);
        chk("T1_sub_addr", {24'b0, addr_a}, 32'd1);
        in_valid = 1'b0; tick();

        // T2: LOAD / STORE / ADDI queued then drained in order
        out_ready = 1'b0;
        set_req(1, 2, 0, 4, 2, 0, 8);  tick();
        set_req(2, 2, 0, 0, 2, 5, 12); tick();
        set_req(4, 0, 0, 1, 0, 0, -1); tick();
        in_valid = 1'b0;
        chk("T2_load", instr_a, 32'h00812203);
        out_ready = 1'b1; tick();
        chk("T2_store", instr_a, 32'h00512623);
        tick();
        chk("T2_addi", instr_a, 32'hFFF00093);
        tick();

        // T3: BEQ with even and odd negative offsets
        out_ready = 1'b0;
        set_req(3, 5, 1, 9, 1, 2, -4); tick();
        chk("T3_beq", instr_a, 32'hFE208EE3);
        out_ready = 1'b1;
        set_req(3, 0, 0, 0, 1, 2, -3); tick();
        chk("T3_beq_odd", instr_a, 32'hFE208EE3);
        in_valid = 1'b0; tick();

        // T4: fill while stalled, fifth request held, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(4, 0, 0, i + 1, 3, 0, 100 + i);
            tick();
        end
        chk("T4_full_rdy", {31'b0, in_ready_a}, 32'd0);
        chk("T4_full_cnt", {29'b0, count_a}, 32'd4);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("T4_drained", {29'b0, count_a}, 32'd0);

        // T5: illegal kind, then reset with occupancy 3
        set_req(6, 0, 0, 1, 1, 1, 0); tick();
        chk("T5_err", {31'b0, err_a}, 32'd1);
        in_valid = 1'b0; tick();
        chk("T5_err_gone", {31'b0, err_a}, 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(4, 0, 0, 2, 2, 0, i); tick();
        end
        in_valid = 1'b0;
        chk("T5_cnt3", {29'b0, count_a}, 32'd3);
        reset = 1'b1; tick();
        chk("T5_rst_cnt", {29'b0, count_a}, 32'd0);
        chk("T5_rst_vld", {31'b0, out_valid_a}, 32'd0);
        chk("T5_rst_addr", {24'b0, addr_a}, 32'd0);
        reset = 1'b0;

        // T6: six words through the 2-bit address instance
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req(0, i, 0, i, i + 1, i + 2, 0); tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("T6_wrap", {30'b0, addr_b}, 32'd2);

        // Random traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    int'($urandom_range(0, 8191)) - 4096);
            in_valid = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
